// File: rtl/usr_deserializer.sv
// Serial-to-parallel receive stage: LSB-first bits are packed into N-bit words and handed off through a valid/ready output register.
// Define USR_DESER_PARITY_EN to append an even-parity bit to every frame and report parity_err alongside each word.
module usr_deserializer #(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 2)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         serial_in,
  input  logic         bit_valid,
  input  logic         sync,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         overflow,
  input  logic         clear_ovf,
  output logic         busy,
  output logic         parity_err
);

`ifdef USR_DESER_PARITY_EN
  localparam int FRAME = N + 1;
`else
  localparam int FRAME = N;
`endif
  // The last bit of a frame is never stored: it is merged straight into the word
  localparam int DW = FRAME - 1;

  typedef enum logic {IDLE, COLLECT} col_state_t;
  typedef enum logic {EMPTY, FULL} out_state_t;

  col_state_t    col_state, col_next;
  out_state_t    out_state, out_next;
  logic [CW-1:0] count, count_next;
  logic [DW-1:0] shreg, shreg_next;
  logic [N-1:0]  word;
  logic          complete;
  logic          load;
  logic          overflow_next;

  always_comb begin
    complete   = bit_valid && !sync && (count == CW'(FRAME - 1));
    col_next   = col_state;
    count_next = count;
    shreg_next = shreg;
    if (sync) begin
      col_next   = IDLE;
      count_next = '0;
      shreg_next = '0;
    end else if (bit_valid) begin
      shreg_next = DW'({serial_in, shreg} >> 1);
      if (complete) begin
        col_next   = IDLE;
        count_next = '0;
      end else begin
        col_next   = COLLECT;
        count_next = count + 1'b1;
      end
    end
  end

`ifdef USR_DESER_PARITY_EN
  assign word = shreg;
`else
  assign word = {serial_in, shreg};
`endif

  // A finished word is taken if the holding register is empty or draining this cycle
  always_comb begin
    out_next      = out_state;
    overflow_next = overflow;
    load          = 1'b0;
    if (clear_ovf) overflow_next = 1'b0;
    if (complete) begin
      if (out_state == EMPTY || out_ready) load = 1'b1;
      else overflow_next = 1'b1;
    end else if (out_state == FULL && out_ready) begin
      out_next = EMPTY;
    end
    if (load) out_next = FULL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_state <= IDLE;
      out_state <= EMPTY;
      count     <= '0;
      shreg     <= '0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      col_state <= col_next;
      out_state <= out_next;
      count     <= count_next;
      shreg     <= shreg_next;
      overflow  <= overflow_next;
      if (load) out_data <= word;
    end
  end

`ifdef USR_DESER_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else if (load) parity_err <= ^shreg ^ serial_in;
  end
`else
  assign parity_err = 1'b0;
`endif

  assign out_valid = (out_state == FULL);
  assign busy      = (col_state == COLLECT);

endmodule

// File: tb/tb_usr_deserializer.sv
// Self-checking bench for usr_deserializer (N=8); expected words are queued as frames are driven and popped when delivered.
module tb_usr_deserializer;
  localparam int N = 8;
`ifdef USR_DESER_PARITY_EN
  localparam int FRAME = N + 1;
`else
  localparam int FRAME = N;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         serial_in;
  logic         bit_valid;
  logic         sync;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         overflow;
  logic         clear_ovf;
  logic         busy;
  logic         parity_err;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] exp_w;

  usr_deserializer #(.N(N)) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid), .sync(sync),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .clear_ovf(clear_ovf), .busy(busy), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation still running, required completion");
    $fatal(1, "[TB] timeout");
  end

  // One full frame, LSB first; options act on the final frame bit only unless ready_all
  task automatic send_word(input logic [N-1:0] data, input bit push, input bit ready_last,
                           input bit clr_last, input bit bad_par, input bit ready_all);
    logic [N:0] frame;
    frame = {(^data) ^ bad_par, data};
    for (int i = 0; i < FRAME; i++) begin
      serial_in = frame[i];
      bit_valid = 1'b1;
      out_ready = ready_all || (ready_last && (i == FRAME - 1));
      clear_ovf = clr_last && (i == FRAME - 1);
      @(posedge clk); #1;
    end
    bit_valid = 1'b0;
    out_ready = 1'b0;
    clear_ovf = 1'b0;
    serial_in = 1'b0;
    if (push) exp_q.push_back(data);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, overflow, busy, parity_err, out_data} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: got %b required 0", {out_valid, overflow, busy, parity_err, out_data});
    end
    rst = 1'b0;
    send_word(8'h11, 1, 0, 0, 0, 0);
    checks++;
    if (exp_q.size() != 0) exp_w = exp_q.pop_front(); else exp_w = 'x;
    if (out_data !== exp_w || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_word: got %h/%b required %h/1", out_data, out_valid, exp_w);
    end
    for (int i = 0; i < 5; i++) begin
      serial_in = 1'b1; bit_valid = 1'b1;
      @(posedge clk); #1;
    end
    bit_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_mid_frame: got %b required 1", busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, overflow, busy, parity_err, out_data} !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset: got %b required 0", {out_valid, overflow, busy, parity_err, out_data});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    send_word(8'h5A, 1, 0, 0, 0, 0);
    checks++;
    if (exp_q.size() != 0) exp_w = exp_q.pop_front(); else exp_w = 'x;
    if (out_data !== exp_w || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_reset_word: got %h/%b required %h/1", out_data, out_valid, exp_w);
    end
    drain();
  endtask

  task automatic test_single_word();
    send_word(8'hA5, 1, 0, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b0 || parity_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_flags: valid/busy/perr got %b%b%b required 100", out_valid, busy, parity_err);
    end
    checks++;
    if (exp_q.size() != 0) exp_w = exp_q.pop_front(); else exp_w = 'x;
    if (out_data !== exp_w) begin
      errors++;
      $display("[TB] FAIL single_data: got %h required %h", out_data, exp_w);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_data !== exp_w || out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL hold_%0d: got %h/%b required %h/1", i, out_data, out_valid, exp_w);
      end
    end
    drain();
    checks++;
    if (out_valid !== 1'b0 || out_data !== exp_w) begin
      errors++;
      $display("[TB] FAIL single_drain: got %h/%b required %h/0", out_data, out_valid, exp_w);
    end
  endtask

  task automatic test_overflow();
    send_word(8'h3C, 1, 0, 0, 0, 0);
    send_word(8'hC3, 0, 0, 0, 0, 0);
    checks++;
    if (exp_q.size() != 0) exp_w = exp_q.pop_front(); else exp_w = 'x;
    if (out_data !== exp_w || overflow !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_drop: data/ovf/valid got %h/%b/%b required %h/1/1", out_data, overflow, out_valid, exp_w);
    end
    clear_ovf = 1'b1;
    @(posedge clk); #1;
    clear_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_clear: got %b required 0", overflow);
    end
    send_word(8'h55, 0, 0, 1, 0, 0);
    checks++;
    if (overflow !== 1'b1 || out_data !== 8'h3C) begin
      errors++;
      $display("[TB] FAIL overflow_set_wins: ovf/data got %b/%h required 1/3c", overflow, out_data);
    end
    clear_ovf = 1'b1;
    @(posedge clk); #1;
    clear_ovf = 1'b0;
  endtask

  task automatic test_simultaneous_drain();
    send_word(8'h81, 1, 1, 0, 0, 0);
    checks++;
    if (exp_q.size() != 0) exp_w = exp_q.pop_front(); else exp_w = 'x;
    if (out_data !== exp_w || out_valid !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL simul_drain: data/valid/ovf got %h/%b/%b required %h/1/0", out_data, out_valid, overflow, exp_w);
    end
    drain();
  endtask

  task automatic test_sync();
    for (int g = 0; g <= 2; g += 2) begin
      for (int i = 0; i < 3; i++) begin
        serial_in = 1'b1; bit_valid = 1'b1;
        @(posedge clk); #1;
        bit_valid = 1'b0;
        repeat (g) @(posedge clk);
        #0;
      end
      serial_in = 1'b1; bit_valid = 1'b1; sync = 1'b1;
      @(posedge clk); #1;
      sync = 1'b0; bit_valid = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL sync_busy_gap%0d: got %b required 0", g, busy);
      end
      for (int i = 0; i < FRAME; i++) begin
        if (i == FRAME - 1) begin
          checks++;
          if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sync_early_word_gap%0d: got valid %b required 0", g, out_valid);
          end
          exp_q.push_back(8'h00);
        end
        serial_in = 1'b0; bit_valid = 1'b1;
        @(posedge clk); #1;
        bit_valid = 1'b0;
        if (i != FRAME - 1) repeat (g) @(posedge clk);
        #0;
      end
      checks++;
      if (exp_q.size() != 0) exp_w = exp_q.pop_front(); else exp_w = 'x;
      if (out_data !== exp_w || out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL sync_word_gap%0d: got %h/%b required %h/1", g, out_data, out_valid, exp_w);
      end
      drain();
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL sync_single_gap%0d: got valid %b required 0", g, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] d;
    for (int k = 0; k < 4; k++) begin
      d = N'($urandom_range(0, 255));
      send_word(d, 1, 0, 0, 0, 1);
      checks++;
      if (exp_q.size() != 0) exp_w = exp_q.pop_front(); else exp_w = 'x;
      if (out_data !== exp_w || out_valid !== 1'b1 || overflow !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_%0d: data/valid/ovf got %h/%b/%b required %h/1/0", k, out_data, out_valid, overflow, exp_w);
      end
    end
    drain();
  endtask

`ifdef USR_DESER_PARITY_EN
  task automatic test_parity();
    send_word(8'hA5, 1, 0, 0, 0, 0);
    checks++;
    if (exp_q.size() != 0) exp_w = exp_q.pop_front(); else exp_w = 'x;
    if (out_data !== exp_w || parity_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL parity_good: data/perr got %h/%b required %h/0", out_data, parity_err, exp_w);
    end
    drain();
    send_word(8'hA5, 1, 0, 0, 1, 0);
    checks++;
    if (exp_q.size() != 0) exp_w = exp_q.pop_front(); else exp_w = 'x;
    if (out_data !== exp_w || parity_err !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL parity_bad: data/perr/valid got %h/%b/%b required %h/1/1", out_data, parity_err, out_valid, exp_w);
    end
    drain();
  endtask
`endif

  initial begin
    rst = 1'b1; serial_in = 1'b0; bit_valid = 1'b0; sync = 1'b0;
    out_ready = 1'b0; clear_ovf = 1'b0;
    test_reset();
    test_single_word();
    test_overflow();
    test_simultaneous_drain();
    test_sync();
    test_back_to_back();
`ifdef USR_DESER_PARITY_EN
    test_parity();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_leftover: got %0d words pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
